// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the RAM burst controller and its read FIFO.
package ram_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned LEN_W_DEF  = 4;

    // Read-return FIFO sizing: three entries cover issue -> RAM -> FIFO -> consumer.
    localparam int unsigned FIFO_DEPTH = 3;
    localparam int unsigned PTR_W      = 2;
    localparam int unsigned CNT_W      = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Circular pointer advance for a non-power-of-two depth.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

endpackage

// File: rtl/ram_rd_fifo.sv
// Small read-return FIFO holding {last, data} beats between RAM and consumer.
module ram_rd_fifo
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned W = DATA_W_DEF + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     pop_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [W-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; empty entries are never presented.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst command sequencer in front of a single-port RAM with registered read data.
module ram_burst_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_rw,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy
);

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  cur_addr;
    logic [LEN_W-1:0]   beats_left;
    logic               inflight;
    logic               inflight_last;
    logic               accept;
    logic               issue;
    logic               wbeat;
    logic               credit_ok;
    logic               drain_done;
    logic               fifo_pop;
    logic               fifo_empty;
    logic               fifo_full;
    logic [CNT_W-1:0]   fifo_count;
    logic [DATA_W:0]    fifo_head;

    // Credits count the beat already travelling through the RAM, so the FIFO cannot overflow.
    assign credit_ok  = ~fifo_full &
                        (((CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight)) < (CNT_W+1)'(FIFO_DEPTH));
    assign fifo_pop   = rd_ready & ~fifo_empty;
    assign drain_done = ~inflight & (fifo_empty | ((fifo_count == CNT_W'(1)) & fifo_pop));

    assign rd_valid = ~fifo_empty;
    assign rd_data  = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
    assign rd_last  = ~fifo_empty & fifo_head[DATA_W];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state, handshakes and RAM bus decode.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        wr_ready  = 1'b0;
        ram_rw    = 1'b1;
        ram_addr  = cur_addr;
        ram_din   = '0;
        accept    = 1'b0;
        issue     = 1'b0;
        wbeat     = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = req_write ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                wr_ready = 1'b1;
                ram_din  = wr_data;
                if (wr_valid) begin
                    ram_rw = 1'b0;
                    wbeat  = 1'b1;
                    if (beats_left == '0) state_nxt = ST_IDLE;
                end
            end
            ST_READ: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (beats_left == '0) state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Burst address/length tracking and the one-cycle read-latency tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr      <= '0;
            beats_left    <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue & (beats_left == '0);
            if (accept) begin
                cur_addr   <= req_addr;
                beats_left <= req_len;
            end else if (issue | wbeat) begin
                cur_addr   <= cur_addr + ADDR_W'(1);
                beats_left <= beats_left - LEN_W'(1);
            end
        end
    end

    ram_rd_fifo #(
        .W(DATA_W + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data ({inflight_last, ram_dout}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Scoreboard bench for ram_burst_ctrl with a behavioural RAM and memory reference.
module tb_ram_burst_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [3:0]  req_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        rd_last;
    logic [15:0] ram_addr;
    logic [31:0] ram_din;
    logic        ram_rw;
    logic [31:0] ram_dout;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] ram_mem [65536];
    logic [31:0] ref_mem [65536];

    typedef struct packed { logic last; logic [31:0] data; } rd_beat_t;
    typedef struct packed { logic [15:0] addr; logic [31:0] data; } wr_beat_t;
    rd_beat_t rd_exp [$];
    wr_beat_t wr_exp [$];

    bit          wr_phase = 0;
    int          rd_mode  = 0;
    int          bp_lo    = 0;
    int          bp_hi    = 0;
    logic [31:0] wq [16];

    ram_burst_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_rw    (ram_rw),
        .ram_dout  (ram_dout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // 64K x 32 single-port RAM, write when rw=0, registered read data.
    always @(posedge clk) begin
        if (ram_rw == 1'b0) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: RAM write bus and read stream against the queued expectations.
    initial begin
        wr_beat_t wb;
        rd_beat_t rb;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("ram_rw", 64'(ram_rw), 64'(!(wr_phase && wr_valid)));
                if (ram_rw == 1'b0) begin
                    if (wr_exp.size() == 0) check("wr_unexpected", 64'(1), 64'(0));
                    else begin
                        wb = wr_exp.pop_front();
                        check("wr_addr", 64'(ram_addr), 64'(wb.addr));
                        check("wr_data", 64'(ram_din), 64'(wb.data));
                    end
                end
                if (rd_valid && rd_ready) begin
                    if (rd_exp.size() == 0) check("rd_unexpected", 64'(1), 64'(0));
                    else begin
                        rb = rd_exp.pop_front();
                        check("rd_data", 64'(rd_data), 64'(rb.data));
                        check("rd_last", 64'(rd_last), 64'(rb.last));
                    end
                end
            end
        end
    end

    // Consumer ready: 0 = always, 1 = random, 2 = low in [bp_lo, bp_hi] else random.
    initial begin
        rd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rd_mode)
                1:       rd_ready = 1'($urandom_range(0, 1));
                2:       rd_ready = (cyc >= bp_lo && cyc <= bp_hi) ? 1'b0 : 1'($urandom_range(0, 1));
                default: rd_ready = 1'b1;
            endcase
        end
    end

    // Present a command; returns the cycle index t in which it was accepted.
    task automatic send_cmd(input bit w, input logic [15:0] a, input logic [3:0] l, output int t);
        int n;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_len   = l;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("req_timeout", 64'(0), 64'(1));
        t = cyc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Write burst from wq[]; valid pattern from pat (bit k = cycle k) or random gaps.
    task automatic do_write(input logic [15:0] a, input logic [3:0] l, input bit use_pat,
                            input logic [31:0] pat);
        int t;
        int k;
        int beat;
        logic v;
        send_cmd(1'b1, a, l, t);
        k = 0;
        beat = 0;
        wr_phase = 1;
        while (beat <= int'(l) && k < 200) begin
            v = (use_pat && k < 32) ? pat[k[4:0]] : 1'($urandom_range(0, 3) != 0);
            wr_valid = v;
            wr_data  = v ? wq[beat] : $urandom;
            if (v) begin
                wr_exp.push_back({16'(int'(a) + beat), wq[beat]});
                ref_mem[16'(int'(a) + beat)] = wq[beat];
                beat++;
            end
            k++;
            @(posedge clk);
            #1;
        end
        wr_valid = 1'b0;
        wr_phase = 0;
        @(negedge clk);
        check("wr_done_busy", 64'(busy), 64'(0));
        check("wr_done_req_ready", 64'(req_ready), 64'(1));
        @(posedge clk);
        #1;
    endtask

    // Read burst; expected beats come from the reference memory.
    task automatic do_read(input logic [15:0] a, input logic [3:0] l, input bit chk_timing,
                           input bit chk_bp);
        int t;
        int first;
        int idle;
        int n;
        for (int i = 0; i <= int'(l); i++)
            rd_exp.push_back({1'(i == int'(l)), ref_mem[16'(int'(a) + i)]});
        send_cmd(1'b0, a, l, t);
        first = -1;
        idle  = -1;
        n = 0;
        while (idle < 0 && n < 300) begin
            @(negedge clk);
            n++;
            if (first < 0 && rd_valid) first = cyc;
            if (!busy) idle = cyc;
            if (chk_bp && (cyc == t + 5 || cyc == t + 10)) begin
                check("bp_credit_addr", 64'(ram_addr), 64'(16'(int'(a) + 3)));
                check("bp_rd_valid", 64'(rd_valid), 64'(1));
            end
        end
        if (idle < 0) check("rd_timeout", 64'(0), 64'(1));
        if (chk_timing) begin
            check("rd_first_latency", 64'(first - t), 64'(3));
            check("rd_idle_latency", 64'(idle - t), 64'(int'(l) + 4));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        logic [15:0] a;
        logic [3:0]  l;

        for (int i = 0; i < 65536; i++) begin
            ram_mem[i] = '0;
            ref_mem[i] = '0;
        end
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;

        // Reset values.
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'(1));
        check("rst_wr_ready", 64'(wr_ready), 64'(0));
        check("rst_rd_valid", 64'(rd_valid), 64'(0));
        check("rst_rd_last", 64'(rd_last), 64'(0));
        check("rst_rd_data", 64'(rd_data), 64'(0));
        check("rst_ram_rw", 64'(ram_rw), 64'(1));
        check("rst_ram_addr", 64'(ram_addr), 64'(0));
        check("rst_ram_din", 64'(ram_din), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single write then read.
        wq[0] = 32'hDEADBEEF;
        do_write(16'h0010, 4'd0, 1'b1, 32'hFFFF_FFFF);
        do_read(16'h0010, 4'd0, 1'b1, 1'b0);

        // 16-beat burst, data 0..15.
        for (int i = 0; i < 16; i++) wq[i] = 32'(i);
        do_write(16'h0100, 4'd15, 1'b1, 32'hFFFF_FFFF);
        do_read(16'h0100, 4'd15, 1'b1, 1'b0);

        // Address wrap.
        wq[0] = 32'hAAAA0001;
        wq[1] = 32'hBBBB0002;
        wq[2] = 32'hCCCC0003;
        wq[3] = 32'hDDDD0004;
        do_write(16'hFFFE, 4'd3, 1'b1, 32'hFFFF_FFFF);
        check("wrap_fffe", 64'(ram_mem[16'hFFFE]), 64'(32'hAAAA0001));
        check("wrap_ffff", 64'(ram_mem[16'hFFFF]), 64'(32'hBBBB0002));
        check("wrap_0000", 64'(ram_mem[16'h0000]), 64'(32'hCCCC0003));
        check("wrap_0001", 64'(ram_mem[16'h0001]), 64'(32'hDDDD0004));
        do_read(16'hFFFE, 4'd3, 1'b1, 1'b0);

        // Backpressure: consumer stalled for cycles t+3..t+10.
        bp_lo   = cyc + 3;
        bp_hi   = cyc + 10;
        rd_mode = 2;
        do_read(16'h0100, 4'd7, 1'b0, 1'b1);
        rd_mode = 0;

        // Write stalls: valid 1,0,0,1,1,0,1.
        for (int i = 0; i < 4; i++) wq[i] = $urandom;
        do_write(16'h0200, 4'd3, 1'b1, 32'h0000_0059);
        do_read(16'h0200, 4'd3, 1'b1, 1'b0);

        // Reset during beat 4 of a 16-beat read.
        for (int i = 0; i < 16; i++)
            rd_exp.push_back({1'(i == 15), ref_mem[16'(16'h0100 + i)]});
        send_cmd(1'b0, 16'h0100, 4'd15, t);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("pre_rst_rd_valid", 64'(rd_valid), 64'(1));
        check("pre_rst_popped", 64'(rd_exp.size()), 64'(13));
        rst = 1'b1;
        #1;
        check("mid_rst_rd_valid", 64'(rd_valid), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_ram_rw", 64'(ram_rw), 64'(1));
        rd_exp.delete();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_read(16'h0010, 4'd0, 1'b1, 1'b0);

        // Randomized bursts against the reference memory.
        for (int it = 0; it < 24; it++) begin
            a = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF4 + $urandom_range(0, 11))
                                            : 16'($urandom);
            l = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) wq[i] = $urandom;
                do_write(a, l, 1'b0, 32'h0);
            end else begin
                rd_mode = 1;
                do_read(a, l, 1'b0, 1'b0);
                rd_mode = 0;
            end
        end

        check("rd_queue_drained", 64'(rd_exp.size()), 64'(0));
        check("wr_queue_drained", 64'(wr_exp.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
